rc4_design: RTL and testbench
=============================

RC4_DESIGN -- requirements
Module: rc4_design

Interface
REQ-001 SHALL have parameter NUMS_OF_BYTES, default 16, giving both the maximum key length and the keystream length in bytes.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-high (1 = reset), keeping the codebase port name.
REQ-005 SHALL have port start, input, 1 bit: run request, level-sensitive.
REQ-006 SHALL have port key, input, NUMS_OF_BYTES*8 bits: key byte n at key[n*8+:8], byte 0 first.
REQ-007 SHALL have port key_length, input, 8 bits: number of valid key bytes.
REQ-008 SHALL have port ckey, output, NUMS_OF_BYTES*8 bits: keystream byte n at ckey[n*8+:8].
REQ-009 SHALL have port done, output, 1 bit: keystream complete and valid.

Function
REQ-010 SHALL compute the standard RC4 keystream of NUMS_OF_BYTES bytes (KSA then PRGA) into a 256x8 S-box; all index and sum arithmetic is mod 256 (8-bit wrap).
REQ-011 SHALL use FSM states IDLE, INIT, KSA, PRGA_SWAP, PRGA_OUT, DONE.
REQ-012 IDLE SHALL go to INIT when start=1, latching key and key_length; start SHALL be ignored in every other state.
REQ-013 SHALL clamp the effective key length: key_length 0 or greater than NUMS_OF_BYTES uses NUMS_OF_BYTES.
REQ-014 INIT SHALL write S[i]=i, one entry per cycle, for 256 cycles, then clear i and j and go to KSA.
REQ-015 KSA SHALL do one iteration per cycle for i=0..255: j=j+S[i]+K[i mod len], swap S[i] and S[j] using the new j; after i=255 it clears i and j, clears the output index, and goes to PRGA_SWAP.
REQ-016 PRGA_SWAP SHALL set i=i+1, j=j+S[i] (new i), swap S[i] and S[j], and register t=S[i]+S[j] from the pre-swap values.
REQ-017 PRGA_OUT SHALL write S[t] (post-swap) into ckey byte n and increment n; it goes to DONE after byte NUMS_OF_BYTES-1, otherwise back to PRGA_SWAP.
REQ-018 A swap with i==j SHALL leave S unchanged.
REQ-019 Total latency SHALL be 512+2*NUMS_OF_BYTES cycles from the start-sampling edge to done=1 (544 for the default).
REQ-020 DONE SHALL hold done=1 and ckey stable while start=1, and go to IDLE when start=0.
REQ-021 done SHALL fall on leaving DONE; ckey SHALL keep its last value until the next run overwrites it byte by byte.
REQ-022 A new run SHALL require start to be 0 for at least one cycle after done.

Reset
REQ-023 rst_n=1 at a clock edge SHALL force IDLE, i=j=t=n=0, done=0 and ckey=0; this applies in any state, including mid-run, and aborts the run.
REQ-024 S-box contents SHALL NOT be reset (INIT rewrites them).
REQ-025 After reset deasserts, start SHALL be sampled on the first following edge.

Configuration
REQ-026 RC4_DEBUG_EN defined SHALL add outputs dbg_state (3 bits, FSM encoding), dbg_i (8) and dbg_j (8), driven from the live registers.
REQ-027 Without RC4_DEBUG_EN those ports SHALL be absent and the core function SHALL be unchanged.

Structure
REQ-028 A shared package rc4_pkg SHALL hold the FSM state enum, SBOX_SIZE=256 and BYTE_W=8.
REQ-029 The S-box SHALL be a sub-module rc4_sbox: 256x8 registers, two asynchronous read ports, and two write ports with a defined same-address rule (port A wins).

Verification
REQ-030 Key 01 02 03 04 05, key_length=5, start held high -> ckey bytes 0..15 = b2 39 63 05 f0 3d c0 27 cc c3 52 4a 0a 11 18 a8, done=1 at cycle 544.
REQ-031 Key "Key" (4b 65 79), key_length=3 -> bytes 0..9 = eb 9f 77 81 b7 34 ca 72 a7 19.
REQ-032 Key "Secret" (53 65 63 72 65 74), key_length=6 -> bytes 0..7 = 04 d4 6b 05 3c a8 7b 59.
REQ-033 Key 01..05 with key_length=0 -> same result as key_length=16 with the same 16-byte key vector; key_length=200 -> identical result.
REQ-034 rst_n pulsed for one cycle at cycle 300 -> done=0 and ckey=0 immediately; the restarted run gives the REQ-030 result 544 cycles after restart.
REQ-035 After done, drop start for one cycle and re-raise it with the "Key" vector -> done falls, then rises 544 cycles later with the REQ-031 bytes.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream generator: S-box geometry and the
// FSM state encoding used by rc4_design (also exported on dbg_state).
package rc4_pkg;

    localparam int SBOX_SIZE = 256;
    localparam int BYTE_W    = 8;

    // FSM state encoding
    typedef logic [2:0] rc4_state_t;

    localparam rc4_state_t IDLE      = 3'd0;
    localparam rc4_state_t INIT      = 3'd1;
    localparam rc4_state_t KSA       = 3'd2;
    localparam rc4_state_t PRGA_SWAP = 3'd3;
    localparam rc4_state_t PRGA_OUT  = 3'd4;
    localparam rc4_state_t DONE      = 3'd5;

endpackage

// File: rtl/rc4_sbox.sv
// RC4 S-box: 256 x 8 register file with two asynchronous read ports and two
// synchronous write ports. When both ports write the same address in the same
// cycle, port A's data is kept. Contents are deliberately not reset.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic [7:0]        raddr_a,
    output logic [BYTE_W-1:0] rdata_a,
    input  logic [7:0]        raddr_b,
    output logic [BYTE_W-1:0] rdata_b,
    input  logic              we_a,
    input  logic [7:0]        waddr_a,
    input  logic [BYTE_W-1:0] wdata_a,
    input  logic              we_b,
    input  logic [7:0]        waddr_b,
    input  logic [BYTE_W-1:0] wdata_b
);

    logic [BYTE_W-1:0] mem [SBOX_SIZE];

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

    // Write ports; port A is assigned last so it wins on an address collision
    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[waddr_b] <= wdata_b;
        end
        if (we_a) begin
            mem[waddr_a] <= wdata_a;
        end
    end

endmodule

// File: rtl/rc4_design.sv
// RC4 keystream generator: on start, runs the key schedule (KSA) over a
// 256-entry S-box and then emits NUMS_OF_BYTES keystream bytes (PRGA) into
// ckey, one byte every two cycles. Latency is 512 + 2*NUMS_OF_BYTES cycles.
// NUMS_OF_BYTES must be in 1..255 (key_length and byte counters are 8 bits).
// Optional macro RC4_DEBUG_EN adds dbg_state/dbg_i/dbg_j outputs.
module rc4_design
    import rc4_pkg::*;
#(
    parameter int NUMS_OF_BYTES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,     // active-high synchronous reset
    input  logic                            start,
    input  logic [NUMS_OF_BYTES*BYTE_W-1:0] key,
    input  logic [7:0]                      key_length,
`ifdef RC4_DEBUG_EN
    output logic [2:0]                      dbg_state,
    output logic [7:0]                      dbg_i,
    output logic [7:0]                      dbg_j,
`endif
    output logic [NUMS_OF_BYTES*BYTE_W-1:0] ckey,
    output logic                            done
);

    localparam logic [7:0] NB8 = 8'(NUMS_OF_BYTES);

    rc4_state_t state;
    logic [7:0] i, j, t, n;
    logic [7:0] k;                           // i mod len, tracked incrementally
    logic [7:0] len;                         // clamped key length of this run
    logic [NUMS_OF_BYTES*BYTE_W-1:0] key_r;

    logic [7:0]        i_nxt, j_new, key_byte, key_len_eff;
    logic [7:0]        raddr_a, raddr_b, waddr_a, waddr_b;
    logic [BYTE_W-1:0] rdata_a, rdata_b, wdata_a, wdata_b;
    logic              we_a, we_b;

    assign i_nxt       = i + 8'd1;
    assign key_byte    = key_r[k * BYTE_W +: BYTE_W];
    assign key_len_eff = (key_length == 8'd0 || key_length > NB8) ? NB8 : key_length;

    // Port A reads S[i] (S[i+1] in PRGA_SWAP) or, for output, S[t]
    always_comb begin
        case (state)
            PRGA_SWAP: raddr_a = i_nxt;
            PRGA_OUT:  raddr_a = t;
            default:   raddr_a = i;
        endcase
    end

    // Updated j; port B reads S[new j] so the swap sees pre-swap values
    always_comb begin
        j_new = j;
        case (state)
            KSA:       j_new = j + rdata_a + key_byte;
            PRGA_SWAP: j_new = j + rdata_a;
            default:   j_new = j;
        endcase
    end

    assign raddr_b = j_new;

    // S-box writes: identity fill in INIT, cross-write swap in KSA/PRGA_SWAP.
    // With i == j both ports write the same old value, so S is unchanged.
    always_comb begin
        we_a    = 1'b0;
        we_b    = 1'b0;
        waddr_a = raddr_a;
        wdata_a = rdata_b;
        waddr_b = j_new;
        wdata_b = rdata_a;
        case (state)
            INIT: begin
                we_a    = 1'b1;
                wdata_a = i;
            end
            KSA, PRGA_SWAP: begin
                we_a = 1'b1;
                we_b = 1'b1;
            end
            default: ;
        endcase
    end

    rc4_sbox u_sbox (
        .clk     (clk),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b),
        .we_a    (we_a),
        .waddr_a (waddr_a),
        .wdata_a (wdata_a),
        .we_b    (we_b),
        .waddr_b (waddr_b),
        .wdata_b (wdata_b)
    );

    // Control FSM, indices and keystream output register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            t     <= 8'd0;
            n     <= 8'd0;
            k     <= 8'd0;
            len   <= NB8;
            key_r <= '0;
            done  <= 1'b0;
            ckey  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_r <= key;
                        len   <= key_len_eff;
                        i     <= 8'd0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    i <= i_nxt;
                    if (i == 8'd255) begin
                        j     <= 8'd0;
                        k     <= 8'd0;
                        state <= KSA;
                    end
                end
                KSA: begin
                    i <= i_nxt;
                    j <= j_new;
                    k <= (k == len - 8'd1) ? 8'd0 : k + 8'd1;
                    if (i == 8'd255) begin
                        j     <= 8'd0;
                        n     <= 8'd0;
                        state <= PRGA_SWAP;
                    end
                end
                PRGA_SWAP: begin
                    i     <= i_nxt;
                    j     <= j_new;
                    t     <= rdata_a + rdata_b;
                    state <= PRGA_OUT;
                end
                PRGA_OUT: begin
                    ckey[n * BYTE_W +: BYTE_W] <= rdata_a;
                    n <= n + 8'd1;
                    if (n == NB8 - 8'd1) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= PRGA_SWAP;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RC4_DEBUG_EN
    assign dbg_state = state;
    assign dbg_i     = i;
    assign dbg_j     = j;
`endif

endmodule

// File: tb/tb_rc4_design.sv
// Directed bench for rc4_design (default NUMS_OF_BYTES = 16): published RC4
// keystreams, key-length clamping against a software RC4 model, done/start
// handshake, latency and mid-run reset.
module tb_rc4_design;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [7:0]   key_length;
    logic [127:0] ckey;
    logic         done;
`ifdef RC4_DEBUG_EN
    logic [2:0]   dbg_state;
    logic [7:0]   dbg_i;
    logic [7:0]   dbg_j;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    localparam logic [127:0] KEY_12345  = 128'h0504030201;
    localparam logic [127:0] KEY_KEY    = 128'h79654b;
    localparam logic [127:0] KEY_SECRET = 128'h746572636553;

    // Reference streams written byte 0 first (leftmost)
    localparam logic [127:0] REF_12345  = 128'hb2396305f03dc027ccc3524a0a1118a8;
    localparam logic [127:0] REF_KEY    = {80'heb9f7781b734ca72a719, 48'h0};
    localparam logic [127:0] REF_SECRET = {64'h04d46b053ca87b59, 64'h0};

    rc4_design #(.NUMS_OF_BYTES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .key_length (key_length),
`ifdef RC4_DEBUG_EN
        .dbg_state  (dbg_state),
        .dbg_i      (dbg_i),
        .dbg_j      (dbg_j),
`endif
        .ckey       (ckey),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the first cnt ckey bytes with a byte-0-first reference
    task automatic chk_stream(input string tag, input logic [127:0] ref_bytes, input int cnt);
        logic [127:0] obs;
        logic [127:0] exp;
        obs = '0;
        exp = '0;
        for (int b = 0; b < cnt; b++) begin
            obs[b*8 +: 8] = ckey[b*8 +: 8];
            exp[b*8 +: 8] = ref_bytes[127 - b*8 -: 8];
        end
        chk(tag, obs, exp);
    endtask

    // Plain software RC4, result in ckey layout (byte n at [n*8+:8])
    function automatic logic [127:0] rc4_model(input logic [127:0] kv, input int len);
        int s [256];
        int a, b, tmp;
        logic [127:0] r;
        for (int x = 0; x < 256; x++) s[x] = x;
        b = 0;
        for (int x = 0; x < 256; x++) begin
            b = (b + s[x] + int'(kv[(x % len)*8 +: 8])) % 256;
            tmp = s[x]; s[x] = s[b]; s[b] = tmp;
        end
        a = 0;
        b = 0;
        r = '0;
        for (int x = 0; x < 16; x++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            r[x*8 +: 8] = 8'(s[(s[a] + s[b]) % 256]);
        end
        return r;
    endfunction

    // Raise start (already #1 past an edge); cyc = edges after the sampling edge
    task automatic run(input logic [127:0] k, input logic [7:0] kl, input bit pulse);
        key        = k;
        key_length = kl;
        start      = 1'b1;
        @(posedge clk);
        #1;
        if (pulse) start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic drop_start(input string tag);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, {127'h0, done}, 128'h0);
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        key        = '0;
        key_length = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", {127'h0, done}, 128'h0);
        chk("reset_ckey", ckey, 128'h0);
        rst_n = 1'b0;

        // Key 01..05, start held high
        run(KEY_12345, 8'd5, 1'b0);
        chk("latency_12345", 128'(cyc), 128'd544);
        chk_stream("stream_12345", REF_12345, 16);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", {127'h0, done}, 128'h1);
        chk_stream("hold_ckey", REF_12345, 16);
        drop_start("done_fall_12345");
        chk_stream("ckey_kept", REF_12345, 16);

        // "Key": new run after one cycle with start low
        run(KEY_KEY, 8'd3, 1'b0);
        chk("latency_key", 128'(cyc), 128'd544);
        chk_stream("stream_key", REF_KEY, 10);
        drop_start("done_fall_key");

        // "Secret" with a one-cycle start pulse; start low mid-run is ignored
        run(KEY_SECRET, 8'd6, 1'b1);
        chk("latency_secret", 128'(cyc), 128'd544);
        chk_stream("stream_secret", REF_SECRET, 8);
        @(posedge clk);
        #1;
        chk("done_pulse_secret", {127'h0, done}, 128'h0);

        // Length clamping: 0, 16 and 200 all use the full 16-byte key
        run(KEY_12345, 8'd0, 1'b0);
        chk("latency_len0", 128'(cyc), 128'd544);
        chk("stream_len0", ckey, rc4_model(KEY_12345, 16));
        drop_start("done_fall_len0");
        run(KEY_12345, 8'd16, 1'b0);
        chk("latency_len16", 128'(cyc), 128'd544);
        chk("stream_len16", ckey, rc4_model(KEY_12345, 16));
        drop_start("done_fall_len16");
        run(KEY_12345, 8'd200, 1'b0);
        chk("latency_len200", 128'(cyc), 128'd544);
        chk("stream_len200", ckey, rc4_model(KEY_12345, 16));
        drop_start("done_fall_len200");

        // Reset at cycle 300 of a run aborts it; start still high restarts it
        key        = KEY_12345;
        key_length = 8'd5;
        start      = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_done", {127'h0, done}, 128'h0);
        chk("abort_ckey", ckey, 128'h0);
        rst_n = 1'b0;
        run(KEY_12345, 8'd5, 1'b0);
        chk("latency_restart", 128'(cyc), 128'd544);
        chk_stream("stream_restart", REF_12345, 16);
        drop_start("done_fall_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
